// File: rtl/decode_pkg.sv
// Shared types for the RV32I/RV64I decode stage: opcodes, ALU/CU operation enums,
// funct constants and the decoded control bundle carried through the output queue.
package decode_pkg;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_OR   = 4'd2,
        ALU_XOR  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRA  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SRL  = 4'd9
    } alu_op_t;

    // M-extension entries sit after CU_ERROR so the base encoding never moves.
    typedef enum logic [5:0] {
        CU_LUI, CU_AUIPC, CU_JAL, CU_JALR,
        CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
        CU_LB, CU_LH, CU_LW, CU_LD, CU_LBU, CU_LHU, CU_LWU,
        CU_SB, CU_SH, CU_SW, CU_SD,
        CU_ADDI, CU_SLTI, CU_SLTIU, CU_XORI, CU_ORI, CU_ANDI,
        CU_SLLI, CU_SRLI, CU_SRAI,
        CU_ADD, CU_SUB, CU_SLL, CU_SLT, CU_SLTU, CU_XOR,
        CU_SRL, CU_SRA, CU_OR, CU_AND,
        CU_ERROR,
        CU_MUL, CU_MULH, CU_MULHSU, CU_MULHU,
        CU_DIV, CU_DIVU, CU_REM, CU_REMU
    } cu_op_t;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;

    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // pc/imm are sized for RV64; narrower builds use the low XLEN bits.
    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        alu_op_t     alu_op;
        cu_op_t      cu_op;
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        logic        alu_src;
        logic        illegal;
    } dec_bundle_t;

endpackage

// File: rtl/decode_core.sv
// Combinational RV32I/RV64I instruction decoder: instr + pc -> dec_bundle_t.
// Optional M-extension decode is enabled by defining DECODE_MEXT_EN.
module decode_core
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output dec_bundle_t     bundle
);

    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [6:0]  shift_hi_s;
    logic [63:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s, shamt_s;
    logic        illegal_s;
    dec_bundle_t dec_s;

    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];
    assign imm_i_s  = {{52{instr[31]}}, instr[31:20]};
    assign imm_s_s  = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b_s  = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u_s  = {{32{instr[31]}}, instr[31:12], 12'h000};
    assign imm_j_s  = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    // RV64 uses instr[25] as shamt[5]; RV32 requires it to be zero via shift_hi_s.
    assign shamt_s    = (XLEN == 64) ? {58'd0, instr[25:20]} : {59'd0, instr[24:20]};
    assign shift_hi_s = (XLEN == 64) ? {instr[31:26], 1'b0} : instr[31:25];

    // Main decode: fills fields per opcode class and raises illegal_s on reserved encodings.
    always_comb begin
        dec_s        = '0;
        dec_s.pc     = 64'(pc);
        dec_s.alu_op = ALU_ADD;
        dec_s.cu_op  = CU_ERROR;
        illegal_s    = 1'b0;
        if (instr[1:0] != 2'b11) begin
            illegal_s = 1'b1;
        end else begin
            case (instr[6:0])
                OPC_LUI, OPC_AUIPC: begin
                    dec_s.rd        = instr[11:7];
                    dec_s.imm       = imm_u_s;
                    dec_s.reg_write = 1'b1;
                    dec_s.cu_op     = (instr[5] == 1'b1) ? CU_LUI : CU_AUIPC;
                end
                OPC_JAL: begin
                    dec_s.rd        = instr[11:7];
                    dec_s.imm       = imm_j_s;
                    dec_s.reg_write = 1'b1;
                    dec_s.cu_op     = CU_JAL;
                end
                OPC_JALR: begin
                    dec_s.rd        = instr[11:7];
                    dec_s.rs1       = instr[19:15];
                    dec_s.imm       = imm_i_s;
                    dec_s.reg_write = 1'b1;
                    dec_s.alu_src   = 1'b1;
                    dec_s.cu_op     = CU_JALR;
                end
                OPC_BRANCH: begin
                    dec_s.rs1    = instr[19:15];
                    dec_s.rs2    = instr[24:20];
                    dec_s.imm    = imm_b_s;
                    dec_s.alu_op = ALU_SUB;
                    case (funct3_s)
                        3'b000:  dec_s.cu_op = CU_BEQ;
                        3'b001:  dec_s.cu_op = CU_BNE;
                        3'b100:  dec_s.cu_op = CU_BLT;
                        3'b101:  dec_s.cu_op = CU_BGE;
                        3'b110:  dec_s.cu_op = CU_BLTU;
                        3'b111:  dec_s.cu_op = CU_BGEU;
                        default: illegal_s   = 1'b1;
                    endcase
                end
                OPC_LOAD: begin
                    dec_s.rd        = instr[11:7];
                    dec_s.rs1       = instr[19:15];
                    dec_s.imm       = imm_i_s;
                    dec_s.reg_write = 1'b1;
                    dec_s.mem_read  = 1'b1;
                    dec_s.alu_src   = 1'b1;
                    case (funct3_s)
                        3'b000:  dec_s.cu_op = CU_LB;
                        3'b001:  dec_s.cu_op = CU_LH;
                        3'b010:  dec_s.cu_op = CU_LW;
                        3'b100:  dec_s.cu_op = CU_LBU;
                        3'b101:  dec_s.cu_op = CU_LHU;
                        3'b011: begin
                            if (XLEN == 64) dec_s.cu_op = CU_LD;
                            else            illegal_s   = 1'b1;
                        end
                        3'b110: begin
                            if (XLEN == 64) dec_s.cu_op = CU_LWU;
                            else            illegal_s   = 1'b1;
                        end
                        default: illegal_s = 1'b1;
                    endcase
                end
                OPC_STORE: begin
                    dec_s.rs1       = instr[19:15];
                    dec_s.rs2       = instr[24:20];
                    dec_s.imm       = imm_s_s;
                    dec_s.mem_write = 1'b1;
                    dec_s.alu_src   = 1'b1;
                    case (funct3_s)
                        3'b000:  dec_s.cu_op = CU_SB;
                        3'b001:  dec_s.cu_op = CU_SH;
                        3'b010:  dec_s.cu_op = CU_SW;
                        3'b011: begin
                            if (XLEN == 64) dec_s.cu_op = CU_SD;
                            else            illegal_s   = 1'b1;
                        end
                        default: illegal_s = 1'b1;
                    endcase
                end
                OPC_OP_IMM: begin
                    dec_s.rd        = instr[11:7];
                    dec_s.rs1       = instr[19:15];
                    dec_s.imm       = imm_i_s;
                    dec_s.reg_write = 1'b1;
                    dec_s.alu_src   = 1'b1;
                    case (funct3_s)
                        F3_ADD:  begin dec_s.cu_op = CU_ADDI;  dec_s.alu_op = ALU_ADD;  end
                        F3_SLT:  begin dec_s.cu_op = CU_SLTI;  dec_s.alu_op = ALU_SLT;  end
                        F3_SLTU: begin dec_s.cu_op = CU_SLTIU; dec_s.alu_op = ALU_SLTU; end
                        F3_XOR:  begin dec_s.cu_op = CU_XORI;  dec_s.alu_op = ALU_XOR;  end
                        F3_OR:   begin dec_s.cu_op = CU_ORI;   dec_s.alu_op = ALU_OR;   end
                        F3_SLL: begin
                            dec_s.imm    = shamt_s;
                            dec_s.cu_op  = CU_SLLI;
                            dec_s.alu_op = ALU_SLL;
                            if (shift_hi_s != F7_ZERO) illegal_s = 1'b1;
                            else                       illegal_s = 1'b0;
                        end
                        F3_SR: begin
                            dec_s.imm    = shamt_s;
                            dec_s.cu_op  = (instr[30] == 1'b1) ? CU_SRAI : CU_SRLI;
                            dec_s.alu_op = (instr[30] == 1'b1) ? ALU_SRA : ALU_SRL;
                            if ((shift_hi_s & ~F7_ALT) != 7'b0000000) illegal_s = 1'b1;
                            else                                      illegal_s = 1'b0;
                        end
                        default: begin dec_s.cu_op = CU_ANDI; dec_s.alu_op = ALU_AND; end
                    endcase
                end
                OPC_OP: begin
                    dec_s.rd        = instr[11:7];
                    dec_s.rs1       = instr[19:15];
                    dec_s.rs2       = instr[24:20];
                    dec_s.reg_write = 1'b1;
                    case (funct7_s)
                        F7_ZERO: begin
                            case (funct3_s)
                                F3_ADD:  begin dec_s.cu_op = CU_ADD;  dec_s.alu_op = ALU_ADD;  end
                                F3_SLL:  begin dec_s.cu_op = CU_SLL;  dec_s.alu_op = ALU_SLL;  end
                                F3_SLT:  begin dec_s.cu_op = CU_SLT;  dec_s.alu_op = ALU_SLT;  end
                                F3_SLTU: begin dec_s.cu_op = CU_SLTU; dec_s.alu_op = ALU_SLTU; end
                                F3_XOR:  begin dec_s.cu_op = CU_XOR;  dec_s.alu_op = ALU_XOR;  end
                                F3_SR:   begin dec_s.cu_op = CU_SRL;  dec_s.alu_op = ALU_SRL;  end
                                F3_OR:   begin dec_s.cu_op = CU_OR;   dec_s.alu_op = ALU_OR;   end
                                default: begin dec_s.cu_op = CU_AND;  dec_s.alu_op = ALU_AND;  end
                            endcase
                        end
                        F7_ALT: begin
                            case (funct3_s)
                                F3_ADD:  begin dec_s.cu_op = CU_SUB; dec_s.alu_op = ALU_SUB; end
                                F3_SR:   begin dec_s.cu_op = CU_SRA; dec_s.alu_op = ALU_SRA; end
                                default: illegal_s = 1'b1;
                            endcase
                        end
`ifdef DECODE_MEXT_EN
                        F7_MULDIV: begin
                            case (funct3_s)
                                3'b000:  dec_s.cu_op = CU_MUL;
                                3'b001:  dec_s.cu_op = CU_MULH;
                                3'b010:  dec_s.cu_op = CU_MULHSU;
                                3'b011:  dec_s.cu_op = CU_MULHU;
                                3'b100:  dec_s.cu_op = CU_DIV;
                                3'b101:  dec_s.cu_op = CU_DIVU;
                                3'b110:  dec_s.cu_op = CU_REM;
                                default: dec_s.cu_op = CU_REMU;
                            endcase
                        end
`endif
                        default: illegal_s = 1'b1;
                    endcase
                end
                default: illegal_s = 1'b1;
            endcase
        end
    end

    // Illegal bundles keep only the PC so downstream can report the faulting address.
    always_comb begin
        if (illegal_s) begin
            bundle         = '0;
            bundle.pc      = 64'(pc);
            bundle.cu_op   = CU_ERROR;
            bundle.illegal = 1'b1;
        end else begin
            bundle = dec_s;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decode_core feeding a DEPTH-entry FIFO with valid/ready on both sides,
// flush, and a saturating illegal-instruction counter. M-extension via DECODE_MEXT_EN.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [3:0]      out_alu_op,
    output logic [5:0]      out_cu_op,
    output logic            out_reg_write,
    output logic            out_mem_write,
    output logic            out_mem_read,
    output logic            out_alu_src,
    output logic            out_illegal,
    output logic [15:0]     illegal_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    dec_bundle_t      core_bundle_s;
    dec_bundle_t      head_s;
    dec_bundle_t      out_bundle_s;
    dec_bundle_t      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [15:0]      illegal_count_r;
    logic             full_s, in_ready_s, out_valid_s, push_s, pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    decode_core #(.XLEN(XLEN)) u_core (
        .instr  (in_instr),
        .pc     (in_pc),
        .bundle (core_bundle_s)
    );

    // No pass-through: a full queue refuses input even while popping.
    assign full_s      = (count_r == CNT_W'(DEPTH));
    assign in_ready_s  = !full_s && !rst;
    assign out_valid_s = (count_r != '0) && !rst;
    assign push_s      = in_valid && in_ready_s;
    assign pop_s       = out_valid_s && out_ready;

    // Queue pointers and occupancy; rst outranks flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage write.
    always_ff @(posedge clk) begin
        if (push_s && !flush) mem_r[wr_ptr_r] <= core_bundle_s;
    end

    // Saturating count of illegal instructions actually enqueued.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_count_r <= 16'h0000;
        end else if (push_s && !flush && core_bundle_s.illegal && (illegal_count_r != 16'hFFFF)) begin
            illegal_count_r <= illegal_count_r + 16'h0001;
        end
    end

    assign head_s       = mem_r[rd_ptr_r];
    assign out_bundle_s = rst ? dec_bundle_t'('0) : head_s;

    assign in_ready      = in_ready_s;
    assign out_valid     = out_valid_s;
    assign out_pc        = out_bundle_s.pc[XLEN-1:0];
    assign out_rs1       = out_bundle_s.rs1;
    assign out_rs2       = out_bundle_s.rs2;
    assign out_rd        = out_bundle_s.rd;
    assign out_imm       = out_bundle_s.imm[XLEN-1:0];
    assign out_alu_op    = out_bundle_s.alu_op;
    assign out_cu_op     = out_bundle_s.cu_op;
    assign out_reg_write = out_bundle_s.reg_write;
    assign out_mem_write = out_bundle_s.mem_write;
    assign out_mem_read  = out_bundle_s.mem_read;
    assign out_alu_src   = out_bundle_s.alu_src;
    assign out_illegal   = out_bundle_s.illegal;
    assign illegal_count = illegal_count_r;

    if (XLEN < 64) begin : g_narrow
        logic unused_hi_s;
        assign unused_hi_s = ^{out_bundle_s.pc[63:XLEN], out_bundle_s.imm[63:XLEN]};
    end

endmodule
